// File: rtl/cbs_pkg.sv
// Shared types and saturating credit arithmetic for the multi-queue credit-based shaper.
package cbs_pkg;

  localparam int CREDIT_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    EXTRA = 2'd2
  } state_t;

  // Positive-direction add: a sign flip of two non-negative operands is treated as overflow.
  function automatic logic signed [CREDIT_W-1:0] sat_add_max(
    input logic signed [CREDIT_W-1:0] a,
    input logic signed [CREDIT_W-1:0] b,
    input logic signed [CREDIT_W-1:0] limit
  );
    logic signed [CREDIT_W-1:0] sum;
    sum = a + b;
    if (!a[CREDIT_W-1] && !b[CREDIT_W-1] && sum[CREDIT_W-1]) begin
      return limit;
    end else if (sum > limit) begin
      return limit;
    end else begin
      return sum;
    end
  endfunction

  function automatic logic signed [CREDIT_W-1:0] sat_add_min(
    input logic signed [CREDIT_W-1:0] a,
    input logic signed [CREDIT_W-1:0] b,
    input logic signed [CREDIT_W-1:0] limit
  );
    logic signed [CREDIT_W-1:0] sum;
    sum = a + b;
    if (a[CREDIT_W-1] && b[CREDIT_W-1] && !sum[CREDIT_W-1]) begin
      return limit;
    end else if (sum < limit) begin
      return limit;
    end else begin
      return sum;
    end
  endfunction

endpackage

// File: rtl/cbs_credit_counter.sv
// Per-queue credit register of the credit-based shaper.
// Optional CBS_GATE_FREEZE_EN: credit holds instead of accruing idle slope while the gate is closed.
module cbs_credit_counter
  import cbs_pkg::*;
(
  input  logic                       clk,
  input  logic                       rstn,
  input  logic signed [CREDIT_W-1:0] idle_slope,
  input  logic signed [CREDIT_W-1:0] send_slope,
  input  logic signed [CREDIT_W-1:0] max_credit,
  input  logic signed [CREDIT_W-1:0] min_credit,
  input  logic                       tvalid,
  input  logic                       gate_open,
  input  logic                       sending,
  output logic signed [CREDIT_W-1:0] credit,
  output logic                       ge_zero
);

  logic signed [CREDIT_W-1:0] credit_next;

  // An empty queue with an open gate drops positive credit back to zero.
  always_comb begin
    credit_next = credit;
    if (!tvalid && gate_open && !credit[CREDIT_W-1]) begin
      credit_next = {CREDIT_W{1'b0}};
    end else if (sending) begin
      credit_next = sat_add_min(credit, send_slope, min_credit);
`ifdef CBS_GATE_FREEZE_EN
    end else if (!gate_open) begin
      credit_next = credit;
`endif
    end else begin
      credit_next = sat_add_max(credit, idle_slope, max_credit);
    end
  end

  // Credit register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      credit <= {CREDIT_W{1'b0}};
    end else begin
      credit <= credit_next;
    end
  end

  assign ge_zero = !credit[CREDIT_W-1];

endmodule

// File: rtl/cbs_multi_queue_scheduler.sv
// Strict-priority selector over NUM_QUEUES credit-shaped AXI4-Stream queues with L1 overhead charging.
// Build option CBS_GATE_FREEZE_EN is applied inside cbs_credit_counter.
module cbs_multi_queue_scheduler
  import cbs_pkg::*;
#(
  parameter int C_AXIS_TDATA_WIDTH = 8,
  parameter int C_AXIS_TKEEP_WIDTH = C_AXIS_TDATA_WIDTH / 8,
  parameter int NUM_QUEUES         = 4,
  parameter int L1_LENGTH_OFFSET   = 24
) (
  input  logic                                       clk,
  input  logic                                       rstn,
  input  logic [CREDIT_W*NUM_QUEUES-1:0]             idle_slope,
  input  logic [CREDIT_W*NUM_QUEUES-1:0]             send_slope,
  input  logic [CREDIT_W*NUM_QUEUES-1:0]             max_credit,
  input  logic [CREDIT_W*NUM_QUEUES-1:0]             min_credit,
  input  logic [NUM_QUEUES-1:0]                      cbs_enable,
  input  logic [NUM_QUEUES-1:0]                      gate_open,
  input  logic [NUM_QUEUES*C_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [NUM_QUEUES*C_AXIS_TKEEP_WIDTH-1:0]   s_axis_tkeep,
  input  logic [NUM_QUEUES-1:0]                      s_axis_tvalid,
  input  logic [NUM_QUEUES-1:0]                      s_axis_tlast,
  output logic [NUM_QUEUES-1:0]                      s_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]              m_axis_tdata,
  output logic [C_AXIS_TKEEP_WIDTH-1:0]              m_axis_tkeep,
  output logic                                       m_axis_tvalid,
  output logic                                       m_axis_tlast,
  input  logic                                       m_axis_tready,
  output logic [CREDIT_W*NUM_QUEUES-1:0]             credit,
  output logic [$clog2(NUM_QUEUES)-1:0]              active_queue,
  output logic                                       busy
);

  localparam int QW         = $clog2(NUM_QUEUES);
  localparam int CNT_W      = 16;
  localparam int EXIT_COUNT = L1_LENGTH_OFFSET - C_AXIS_TKEEP_WIDTH;

  state_t              state;
  state_t              state_next;
  logic [QW-1:0]       active_queue_next;
  logic [CNT_W-1:0]    l1_count;
  logic [CNT_W-1:0]    l1_count_next;
  logic [NUM_QUEUES-1:0] eligible;
  logic [NUM_QUEUES-1:0] ge_zero;
  logic [NUM_QUEUES-1:0] sending;
  logic                handshake;
  logic                grant_any;
  logic [QW-1:0]       grant_q;

  assign eligible  = s_axis_tvalid & gate_open & (~cbs_enable | ge_zero);
  assign handshake = (state == SEND) && s_axis_tvalid[active_queue] && m_axis_tready;
  assign busy      = (state != IDLE);

  for (genvar g = 0; g < NUM_QUEUES; g++) begin : g_queue
    // The sending queue is charged for data beats and for every overhead cycle.
    assign sending[g] = (active_queue == QW'(g)) && (handshake || (state == EXTRA));

    cbs_credit_counter u_credit (
      .clk        (clk),
      .rstn       (rstn),
      .idle_slope (idle_slope[g*CREDIT_W +: CREDIT_W]),
      .send_slope (send_slope[g*CREDIT_W +: CREDIT_W]),
      .max_credit (max_credit[g*CREDIT_W +: CREDIT_W]),
      .min_credit (min_credit[g*CREDIT_W +: CREDIT_W]),
      .tvalid     (s_axis_tvalid[g]),
      .gate_open  (gate_open[g]),
      .sending    (sending[g]),
      .credit     (credit[g*CREDIT_W +: CREDIT_W]),
      .ge_zero    (ge_zero[g])
    );
  end

  // Highest-index eligible queue wins; later iterations override earlier ones.
  always_comb begin
    grant_any = 1'b0;
    grant_q   = {QW{1'b0}};
    for (int q = 0; q < NUM_QUEUES; q++) begin
      grant_q   = eligible[q] ? QW'(q) : grant_q;
      grant_any = grant_any | eligible[q];
    end
  end

  // Output mux and ready steering for the latched queue.
  always_comb begin
    m_axis_tdata  = s_axis_tdata[int'(active_queue)*C_AXIS_TDATA_WIDTH +: C_AXIS_TDATA_WIDTH];
    m_axis_tkeep  = s_axis_tkeep[int'(active_queue)*C_AXIS_TKEEP_WIDTH +: C_AXIS_TKEEP_WIDTH];
    m_axis_tlast  = s_axis_tlast[active_queue];
    m_axis_tvalid = 1'b0;
    s_axis_tready = {NUM_QUEUES{1'b0}};
    if (state == SEND) begin
      m_axis_tvalid               = s_axis_tvalid[active_queue];
      s_axis_tready[active_queue] = m_axis_tready;
    end else begin
      m_axis_tvalid = 1'b0;
    end
  end

  // Next-state logic: grant in IDLE, stream until tlast, then burn L1 overhead.
  always_comb begin
    state_next        = state;
    active_queue_next = active_queue;
    l1_count_next     = l1_count;
    case (state)
      IDLE: begin
        if (grant_any) begin
          state_next        = SEND;
          active_queue_next = grant_q;
        end else begin
          state_next = IDLE;
        end
      end
      SEND: begin
        if (handshake && s_axis_tlast[active_queue]) begin
          state_next    = EXTRA;
          l1_count_next = {CNT_W{1'b0}};
        end else begin
          state_next = SEND;
        end
      end
      EXTRA: begin
        l1_count_next = l1_count + CNT_W'(C_AXIS_TKEEP_WIDTH);
        if (int'(l1_count) >= EXIT_COUNT) begin
          state_next = IDLE;
        end else begin
          state_next = EXTRA;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, grant and overhead counter registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state        <= IDLE;
      active_queue <= {QW{1'b0}};
      l1_count     <= {CNT_W{1'b0}};
    end else begin
      state        <= state_next;
      active_queue <= active_queue_next;
      l1_count     <= l1_count_next;
    end
  end

endmodule

// File: doc/cbs_multi_queue_scheduler.md
# cbs_multi_queue_scheduler

Multi-class transmission selector for one egress port: NUM_QUEUES AXI4-Stream queues, each with its own credit-based shaper credit, merged onto one output by strict priority. Per-queue gate inputs come from the TSN gate control list; L1 overhead (FCS, preamble, IPG) is charged to the sending queue's credit. The block sits between the per-class egress FIFOs and the MAC TX interface.

## Interface
- C_AXIS_TDATA_WIDTH, 8, data width in bits
- C_AXIS_TKEEP_WIDTH, C_AXIS_TDATA_WIDTH/8, keep width
- NUM_QUEUES, 4, number of traffic classes (2..8); higher index = higher priority
- L1_LENGTH_OFFSET, 24, extra bytes charged per frame
- clk  in  1  clock
- rstn  in  1  reset; one clock; reset is synchronous and active-low
- idle_slope, send_slope, max_credit, min_credit  in  32*NUM_QUEUES each  per-queue signed settings, queue q at [32q+31:32q]
- cbs_enable  in  NUM_QUEUES  1 = queue shaped; 0 = queue ignores credit (strict priority only)
- gate_open  in  NUM_QUEUES  transmission gate state per queue
- s_axis_tdata/tkeep  in  NUM_QUEUES*width  flattened per queue
- s_axis_tvalid, s_axis_tlast  in  NUM_QUEUES; s_axis_tready  out  NUM_QUEUES
- m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast  out; m_axis_tready  in
- credit  out  32*NUM_QUEUES  debug, current credits
- active_queue  out  $clog2(NUM_QUEUES)  debug, latched grant; busy  out  1  state != IDLE

## Operation
- Eligible(q) = s_axis_tvalid[q] & gate_open[q] & (!cbs_enable[q] | credit[q] >= 0).
- FSM IDLE/SEND/EXTRA. IDLE: if any eligible, latch highest-index eligible q into active_queue, go SEND. No preemption.
- SEND: m_axis_* = queue active_queue; s_axis_tready[active_queue] = m_axis_tready; other treadys 0. Handshake with tlast → EXTRA, counter cleared.
- EXTRA: output tvalid 0, all treadys 0; counter += C_AXIS_TKEEP_WIDTH per cycle; leave to IDLE on the cycle counter reaches ≥ L1_LENGTH_OFFSET − C_AXIS_TKEEP_WIDTH (ceil(L1_LENGTH_OFFSET/KEEP) cycles total; 24 cycles at 8-bit).
- Gate close during SEND does not abort; frame completes.
- Credit per queue each cycle, first matching rule:
  1. s_axis_tvalid[q]=0 & gate_open[q] & credit ≥ 0 → 0.
  2. q is active and (handshake this cycle or state EXTRA) → credit+send_slope, saturate at min_credit; sign-flip underflow → min_credit.
  3. otherwise → credit+idle_slope, saturate at max_credit; sign-flip overflow → max_credit.
- Credit updates run for all queues regardless of cbs_enable; the flag only affects eligibility.
- All adds 32-bit signed; overflow is detected by operand/result sign, not widening.

## Timing
- Reset: state IDLE, credits 0, active_queue 0, busy 0, m_axis_tvalid 0, all s_axis_tready 0, counter 0.
- Eligibility sampled in IDLE; m_axis_tvalid rises the next cycle (1-cycle grant latency). Data path combinational from input to output in SEND.
- Min frame-to-frame gap on output: EXTRA cycles + 1 IDLE cycle.
- m_axis_tvalid never depends on m_axis_tready; tready path is combinational.
- Reset mid-frame: everything returns to reset values next cycle; the partial frame is not completed.
- Queue tvalid dropping mid-frame (upstream bug): no recovery; the block waits in SEND.

## Configuration
- CBS_GATE_FREEZE_EN defined: rule 3 is replaced by a hold when gate_open[q]=0 (credit frozen while gate closed, per 802.1Qbv). Rules 1–2 are unchanged.
- Not defined: idle slope accrues whether or not the gate is open.

## Structure
- Package cbs_pkg: CREDIT_W=32, state enum {IDLE,SEND,EXTRA}, saturating signed add functions sat_add_max/sat_add_min.
- Sub-module cbs_credit_counter: one instance per queue via generate. Implements rules 1–3 and the freeze macro. Outputs credit and a ge_zero flag.
- Top level: arbiter/FSM, L1 counter, output mux.

## Test plan
- Single queue, idle_slope=1, send_slope=-3, max=100, min=-100, 64-beat frame, 8-bit → credit -(64+24)*3 = -264 clamps to -100; next frame starts only after 100 idle cycles.
- Queues 0 and 3 both valid, credit ≥0 → queue 3 granted first; queue 0 follows after 24 EXTRA + 1 IDLE cycles.
- Queue 3 credit -5, cbs_enable[3]=1, queue 1 eligible → queue 1 granted; with cbs_enable[3]=0 → queue 3 granted.
- gate_open[2] drops at beat 10 of 40 → all 40 beats delivered, then no new grant to queue 2.
- Macro on: gate closed 50 cycles with credit -20, idle_slope 1 → credit stays -20; macro off → credit reaches max 30 at 20+30 cycles.
- rstn low at beat 5 with m_axis_tready stalled → next cycle tvalid 0, credits 0, busy 0; overflow case credit 0x7FFFFFF0 + 0x20 → max_credit.
